// File: rtl/cpu_bus_responder.sv
// CPU external bus target: serves a mirrored internal work RAM and forwards every
// other address to a downstream req/ack port, stalling the CPU through rdy.
module cpu_bus_responder #(
   parameter int unsigned ADDR_WIDTH    = 16,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned RAM_ADDR_BITS = 11,
   parameter int unsigned RAM_LIMIT     = 'h2000,
   parameter int unsigned RAM_WAIT      = 0,
   parameter int unsigned EXT_TIMEOUT   = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  bus_valid,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  r_w_n,
   input  logic [DATA_WIDTH-1:0] d_in,
   output logic [DATA_WIDTH-1:0] d_out,
   output logic                  d_oe,
   output logic                  rdy,
   output logic                  ext_req,
   output logic                  ext_we,
   output logic [ADDR_WIDTH-1:0] ext_addr,
   output logic [DATA_WIDTH-1:0] ext_wdata,
   input  logic [DATA_WIDTH-1:0] ext_rdata,
   input  logic                  ext_ack,
   output logic                  bus_err
);

   typedef enum logic [1:0] {StIdle, StRamWait, StExtReq, StDone} state_e;

   // One counter serves both the RAM wait and the ack timeout; the states never overlap.
   localparam int unsigned CntMax = (RAM_WAIT > EXT_TIMEOUT) ? RAM_WAIT : EXT_TIMEOUT;
   localparam int unsigned CntW   = $clog2(CntMax + 2);
   localparam logic [CntW-1:0] RamWaitCnt    = CntW'(RAM_WAIT);
   localparam logic [CntW-1:0] ExtTimeoutCnt = CntW'(EXT_TIMEOUT);

   state_e                   state_q, state_d;
   logic [CntW-1:0]          cnt_q, cnt_d;
   logic [RAM_ADDR_BITS-1:0] idx_q;
   logic                     rd_q;
   logic [DATA_WIDTH-1:0]    wdata_q;
   logic [DATA_WIDTH-1:0]    d_out_q;
   logic                     ext_we_q;
   logic [ADDR_WIDTH-1:0]    ext_addr_q;
   logic [DATA_WIDTH-1:0]    ext_wdata_q;
   logic                     bus_err_q;

   logic ram_hit;
   logic accept;
   logic ram_go;
   logic ext_done;
   logic ext_abort;

   logic [DATA_WIDTH-1:0] ram [2**RAM_ADDR_BITS];

   assign ram_hit = (32'(addr) < RAM_LIMIT);

   // Next-state and counter logic; also flags the events the datapath acts on.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      accept    = 1'b0;
      ram_go    = 1'b0;
      ext_done  = 1'b0;
      ext_abort = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus_valid) begin
               accept = 1'b1;
               if (ram_hit) begin
                  state_d = StRamWait;
                  cnt_d   = RamWaitCnt;
               end else begin
                  state_d = StExtReq;
                  cnt_d   = '0;
               end
            end
         end
         StRamWait: begin
            if (cnt_q == '0) begin
               ram_go  = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StExtReq: begin
            // An ack on the final timer cycle still wins over the abort.
            if (ext_ack) begin
               ext_done = 1'b1;
               state_d  = StDone;
               cnt_d    = '0;
            end else if (cnt_q == ExtTimeoutCnt) begin
               ext_abort = 1'b1;
               state_d   = StDone;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Access latches, downstream request fields, read data and error pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q       <= '0;
         rd_q        <= 1'b0;
         wdata_q     <= '0;
         d_out_q     <= '0;
         ext_we_q    <= 1'b0;
         ext_addr_q  <= '0;
         ext_wdata_q <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         bus_err_q <= ext_abort | (bus_valid & (state_q != StIdle));
         if (accept) begin
            idx_q   <= addr[RAM_ADDR_BITS-1:0];
            rd_q    <= r_w_n;
            wdata_q <= d_in;
            // Downstream fields only move on external accesses, so they stay stable
            // for the whole request and ignore strobes that arrive while busy.
            if (!ram_hit) begin
               ext_addr_q  <= addr;
               ext_we_q    <= ~r_w_n;
               ext_wdata_q <= d_in;
            end
         end
         if (rd_q) begin
            if (ram_go) begin
               d_out_q <= ram[idx_q];
            end else if (ext_done) begin
               d_out_q <= ext_rdata;
            end else if (ext_abort) begin
               d_out_q <= '1;
            end
         end
      end
   end

   // RAM write port; contents survive reset, but a write caught by reset is dropped.
   always_ff @(posedge clk) begin
      if (!reset && ram_go && !rd_q) begin
         ram[idx_q] <= wdata_q;
      end
   end

   assign rdy       = (state_q == StIdle) || (state_q == StDone);
   assign d_oe      = (state_q == StDone) && rd_q;
   assign d_out     = d_out_q;
   assign ext_req   = (state_q == StExtReq);
   assign ext_we    = ext_we_q;
   assign ext_addr  = ext_addr_q;
   assign ext_wdata = ext_wdata_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Randomised bench for cpu_bus_responder: per-cycle expectations come from the access
// latency rules and a byte-array model of the mirrored RAM.
module tb_cpu_bus_responder;

   localparam int unsigned AW          = 16;
   localparam int unsigned DW          = 8;
   localparam int unsigned RB          = 11;
   localparam int unsigned RAM_LIMIT   = 'h2000;
   localparam int unsigned RAM_WAIT    = 0;
   localparam int unsigned EXT_TIMEOUT = 15;

   logic          clk = 1'b0;
   logic          reset;
   logic          bus_valid;
   logic [AW-1:0] addr;
   logic          r_w_n;
   logic [DW-1:0] d_in;
   logic [DW-1:0] d_out;
   logic          d_oe;
   logic          rdy;
   logic          ext_req;
   logic          ext_we;
   logic [AW-1:0] ext_addr;
   logic [DW-1:0] ext_wdata;
   logic [DW-1:0] ext_rdata;
   logic          ext_ack;
   logic          bus_err;

   cpu_bus_responder #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .RAM_ADDR_BITS(RB),
      .RAM_LIMIT    (RAM_LIMIT),
      .RAM_WAIT     (RAM_WAIT),
      .EXT_TIMEOUT  (EXT_TIMEOUT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus_valid(bus_valid),
      .addr     (addr),
      .r_w_n    (r_w_n),
      .d_in     (d_in),
      .d_out    (d_out),
      .d_oe     (d_oe),
      .rdy      (rdy),
      .ext_req  (ext_req),
      .ext_we   (ext_we),
      .ext_addr (ext_addr),
      .ext_wdata(ext_wdata),
      .ext_rdata(ext_rdata),
      .ext_ack  (ext_ack),
      .bus_err  (bus_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference state: RAM image with written-flags, last read value, pending error pulse.
   logic [DW-1:0] mem   [2**RB];
   bit            known [2**RB];
   logic [DW-1:0] last_dout;
   bit            dout_known;
   bit            pending_err;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // One CPU access starting at the current negedge (cycle k=0 is the strobe cycle).
   // ack_dly: number of request cycles before ext_ack; beyond EXT_TIMEOUT means never.
   // stray_k: cycle (>=1) carrying an extra strobe while busy, 0 for none.
   task automatic access(input logic [AW-1:0] a, input bit rnw, input logic [DW-1:0] wd,
                         input logic [DW-1:0] rd_val, input int ack_dly, input int stray_k);
      bit            is_ram;
      bit            tmo;
      int            done_k;
      logic [RB-1:0] idx;
      logic [DW-1:0] exp_rd;
      bit            exp_known;
      bit            exp_err;
      is_ram = (32'(a) < RAM_LIMIT);
      tmo    = !is_ram && (ack_dly > int'(EXT_TIMEOUT));
      if (is_ram)   done_k = 2 + int'(RAM_WAIT);
      else if (tmo) done_k = 2 + int'(EXT_TIMEOUT);
      else          done_k = 2 + ack_dly;
      idx = a[RB-1:0];
      if (is_ram) begin
         exp_rd    = mem[idx];
         exp_known = known[idx];
      end else begin
         exp_rd    = tmo ? 8'hFF : rd_val;
         exp_known = 1'b1;
      end
      for (int k = 0; k <= done_k; k++) begin
         exp_err     = pending_err;
         pending_err = 1'b0;
         if (tmo && k == done_k) exp_err = 1'b1;
         check_eq("bus_err", 32'(bus_err), 32'(exp_err));
         if (k == 0) begin
            check_eq("rdy_idle", 32'(rdy), 32'(1));
            check_eq("req_idle", 32'(ext_req), 32'(0));
            check_eq("oe_idle", 32'(d_oe), 32'(0));
         end else if (k < done_k) begin
            check_eq("rdy_busy", 32'(rdy), 32'(0));
            check_eq("req_busy", 32'(ext_req), 32'(!is_ram));
            check_eq("oe_busy", 32'(d_oe), 32'(0));
            if (!is_ram) begin
               check_eq("ext_addr", 32'(ext_addr), 32'(a));
               check_eq("ext_we", 32'(ext_we), 32'(!rnw));
               if (!rnw) check_eq("ext_wdata", 32'(ext_wdata), 32'(wd));
            end
         end else begin
            check_eq("rdy_done", 32'(rdy), 32'(1));
            check_eq("req_done", 32'(ext_req), 32'(0));
            check_eq("oe_done", 32'(d_oe), 32'(rnw));
         end
         if (k == done_k && rnw) begin
            if (exp_known) check_eq("d_out_rd", 32'(d_out), 32'(exp_rd));
            last_dout  = exp_rd;
            dout_known = exp_known;
         end else if (dout_known) begin
            check_eq("d_out_hold", 32'(d_out), 32'(last_dout));
         end
         // Drive this cycle's inputs.
         bus_valid = (k == 0) || (k >= 1 && k == stray_k);
         addr      = (k == 0) ? a : AW'($urandom);
         r_w_n     = (k == 0) ? rnw : 1'($urandom);
         d_in      = (k == 0) ? wd : DW'($urandom);
         ext_ack   = 1'b0;
         ext_rdata = DW'($urandom);
         if (!is_ram && !tmo && k == 1 + ack_dly) begin
            ext_ack   = 1'b1;
            ext_rdata = rd_val;
         end else if (k == 0 || k == done_k) begin
            ext_ack = 1'($urandom);
         end
         if (k >= 1 && k == stray_k) pending_err = 1'b1;
         @(negedge clk);
      end
      bus_valid = 1'b0;
      ext_ack   = 1'b0;
      if (is_ram && !rnw) begin
         mem[idx]   = wd;
         known[idx] = 1'b1;
      end
   endtask

   task automatic idle_cycle();
      check_eq("bus_err_idle", 32'(bus_err), 32'(pending_err));
      pending_err = 1'b0;
      check_eq("rdy_gap", 32'(rdy), 32'(1));
      check_eq("oe_gap", 32'(d_oe), 32'(0));
      bus_valid = 1'b0;
      ext_ack   = 1'($urandom);
      @(negedge clk);
      ext_ack = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_rdy"}, 32'(rdy), 32'(1));
      check_eq({tag, "_oe"}, 32'(d_oe), 32'(0));
      check_eq({tag, "_dout"}, 32'(d_out), 32'(0));
      check_eq({tag, "_req"}, 32'(ext_req), 32'(0));
      check_eq({tag, "_we"}, 32'(ext_we), 32'(0));
      check_eq({tag, "_eaddr"}, 32'(ext_addr), 32'(0));
      check_eq({tag, "_ewdata"}, 32'(ext_wdata), 32'(0));
      check_eq({tag, "_err"}, 32'(bus_err), 32'(0));
   endtask

   initial begin
      logic [AW-1:0] a;
      int            stray;
      for (int i = 0; i < 2**RB; i++) known[i] = 1'b0;
      reset     = 1'b1;
      bus_valid = 1'b0;
      addr      = '0;
      r_w_n     = 1'b1;
      d_in      = '0;
      ext_rdata = '0;
      ext_ack   = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      reset       = 1'b0;
      last_dout   = '0;
      dout_known  = 1'b1;
      pending_err = 1'b0;
      @(negedge clk);

      // Directed cases.
      access(16'h0010, 1'b0, 8'hA5, 8'h00, 0, 0);
      access(16'h0010, 1'b1, 8'h00, 8'h00, 0, 0);
      access(16'h0805, 1'b0, 8'h3C, 8'h00, 0, 0);
      access(16'h1805, 1'b1, 8'h00, 8'h00, 0, 0);
      access(16'h0005, 1'b1, 8'h00, 8'h00, 0, 0);
      access(16'h8000, 1'b1, 8'h00, 8'h42, 3, 0);
      access(16'h4016, 1'b1, 8'h00, 8'h00, 100, 0);
      access(16'h8123, 1'b1, 8'h00, 8'h9E, 6, 3);
      access(16'hC000, 1'b0, 8'h6D, 8'h00, 2, 0);
      access(16'h0010, 1'b1, 8'h00, 8'h00, 0, 2);
      idle_cycle();

      // Reset during a RAM write: the write must not land.
      access(16'h0123, 1'b0, 8'h5A, 8'h00, 0, 0);
      bus_valid = 1'b1; addr = 16'h0123; r_w_n = 1'b0; d_in = 8'h77;
      @(negedge clk);
      bus_valid = 1'b0;
      check_eq("rst_ram_rdy", 32'(rdy), 32'(0));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_outputs("rst_ram");
      last_dout = '0;
      @(negedge clk);

      // Reset while a downstream request is outstanding.
      bus_valid = 1'b1; addr = 16'h9000; r_w_n = 1'b1; d_in = 8'h00;
      @(negedge clk);
      bus_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         check_eq("rst_ext_req", 32'(ext_req), 32'(1));
         if (k == 3) reset = 1'b1;
         @(negedge clk);
      end
      reset = 1'b0;
      check_reset_outputs("rst_ext");
      @(negedge clk);
      access(16'h0123, 1'b1, 8'h00, 8'h00, 0, 0);
      access(16'h0923, 1'b1, 8'h00, 8'h00, 0, 0);

      // Randomised traffic.
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 1) == 0) a = AW'($urandom_range(0, 'h1FFF));
         else                           a = AW'($urandom_range('h2000, 'hFFFF));
         stray = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         access(a, 1'($urandom), DW'($urandom), DW'($urandom),
                int'($urandom_range(0, 18)), stray);
         if ($urandom_range(0, 2) == 0) idle_cycle();
      end
      idle_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard bound on run time.
   initial begin
      #2000000;
      $display("FAIL timeout: observed no finish, expected finish within bound");
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Target-side agent for the CPU's external address/data bus; answers every CPU read/write cycle.
- Serves an internal mirrored work RAM directly.
- Forwards all other addresses to a downstream memory-mapped port through a req/ack handshake.
- Drives rdy low to stall the CPU until each access completes; sits between cpu_top pins and the system memory map.

Parameters:
ADDR_WIDTH, 16, CPU address bus width
DATA_WIDTH, 8, CPU data bus width
RAM_ADDR_BITS, 11, internal RAM index width (2 KiB)
RAM_LIMIT, 16'h2000, addresses below this hit internal RAM, mirrored every 2^RAM_ADDR_BITS bytes
RAM_WAIT, 0, extra stall cycles on internal RAM accesses
EXT_TIMEOUT, 15, cycles to wait for ext_ack before abort

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
bus_valid  input  1  one-cycle strobe: addr, r_w_n, d_in valid this cycle
addr  input  ADDR_WIDTH  CPU address
r_w_n  input  1  1 = read, 0 = write
d_in  input  DATA_WIDTH  CPU write data
d_out  output  DATA_WIDTH  read data to CPU
d_oe  output  1  d_out valid; drive D this cycle
rdy  output  1  1 = CPU may proceed, 0 = stall
ext_req  output  1  downstream request, held until ext_ack or timeout
ext_we  output  1  downstream write enable
ext_addr  output  ADDR_WIDTH  downstream address
ext_wdata  output  DATA_WIDTH  downstream write data
ext_rdata  input  DATA_WIDTH  downstream read data, valid with ext_ack
ext_ack  input  1  downstream completion
bus_err  output  1  one-cycle pulse: timeout or strobe while busy

Behaviour:
- Reset values: state IDLE, rdy=1, d_oe=0, d_out=0, ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0, bus_err=0, counters 0.
- RAM contents are not cleared by reset.
- Reset mid-operation aborts the access: ext_req drops at that edge; a pending RAM write is not committed.
- States: IDLE, RAM_WAIT, EXT_REQ, DONE.
- IDLE, bus_valid=1:
  - Latch addr, r_w_n, d_in; rdy goes 0 next cycle.
  - addr < RAM_LIMIT -> RAM_WAIT, count = RAM_WAIT.
  - Otherwise -> EXT_REQ: ext_req=1, ext_addr/ext_we(=!r_w_n)/ext_wdata from latched values.
- RAM_WAIT:
  - When count == 0, perform the access at index addr[RAM_ADDR_BITS-1:0] and go to DONE.
  - Otherwise decrement count.
  - Write: RAM[index] <= d_in. Read: d_out <= RAM[index].
- EXT_REQ:
  - ext_ack=1 -> ext_req=0 at that edge; on a read, d_out <= ext_rdata; go to DONE.
  - Without ack, timer increments. ext_ack absent on the cycle timer reaches EXT_TIMEOUT -> abort: ext_req=0, d_out=8'hFF on reads, bus_err pulse, go to DONE.
  - ext_addr/ext_we/ext_wdata stay stable while ext_req=1.
- DONE (one cycle):
  - rdy=1; d_oe=1 only for reads; then IDLE. d_oe deasserts next cycle.
  - d_out holds its value until the next read completes.
- Latency, from the bus_valid cycle N:
  - RAM access: DONE at N+2+RAM_WAIT.
  - External access: DONE one cycle after the ack cycle.
- rdy=0 from N+1 through the cycle before DONE. A write still passes through DONE (rdy=1, d_oe=0).
- bus_valid while not IDLE (including DONE): strobe ignored, bus_err pulses next cycle, current access unaffected.
- bus_valid in the cycle after DONE (state IDLE) is accepted normally; back-to-back accesses are legal.
- ext_ack while not in EXT_REQ: ignored.
- Mirroring: only the low RAM_ADDR_BITS select the byte; addr 0x0801 aliases 0x0001.

Test Plan:
- Reset, then write 8'hA5 to 0x0010, read 0x0010 -> d_out=8'hA5 with d_oe=1 at N+2; rdy low exactly one cycle per access (RAM_WAIT=0).
- Write 8'h3C to 0x0805, read 0x1805 and 0x0005 -> both return 8'h3C (mirroring).
- Read 0x8000, ext_ack with ext_rdata=8'h42 after 3 cycles -> ext_req high 4 cycles, ext_we=0, d_out=8'h42, d_oe one cycle, rdy back high.
- Read 0x4016, never ack -> ext_req drops after EXT_TIMEOUT cycles, d_out=8'hFF, bus_err one pulse, rdy returns 1.
- bus_valid during an external wait -> bus_err pulse, ext_addr unchanged, original access completes correctly.
- Assert reset while ext_req=1 -> next cycle ext_req=0, rdy=1, state IDLE; subsequent RAM read of a prior-written location returns the old data.
